// File: rtl/digit_counter.sv
// -----------------------------------------------------------------------------
// digit_counter
//
// Two-digit BCD seconds counter fed by the button controller. While `set` is
// high each digit is forced to 9 or 0 from `set9`. Otherwise, with `run` high,
// the value advances by one every TICK_DIV clock cycles from 00 toward 99.
//
// Optional feature (compile-time macro): DIGIT_COUNTER_WRAP_EN
//   defined   : a step taken at 99 rolls over to 00 and pulses `tick`.
//   undefined : a step at 99 is dropped; the value holds at 99 with no `tick`.
//
// Parameters
//   TICK_DIV : clk cycles per count step (minimum 2).
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   set     in   set-mode request (level)
//   set9    in   [1] tens preset, [0] ones preset; 1 -> 9, 0 -> 0
//   run     in   count enable when not in set mode (level)
//   tens    out  BCD tens digit (registered)
//   ones    out  BCD ones digit (registered)
//   tick    out  one-cycle pulse after each applied count step (registered)
//   at_max  out  high while the value is 99 (decoded from the digit registers)
// -----------------------------------------------------------------------------
module digit_counter #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set,
    input  logic [1:0] set9,
    input  logic       run,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       tick,
    output logic       at_max
);

    localparam int             PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PRESC_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q,  tens_d;
    logic [3:0]    ones_q,  ones_d;
    logic          tick_q,  tick_d;

    // Counting only progresses while we are in RUN and stay in RUN; a `set`
    // or a falling `run` on the same edge pre-empts the step.
    logic          stay_run;
    logic          period_done;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic (`set` has priority from every state)
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (set) begin
            state_d = ST_SET;
        end else begin
            case (state_q)
                ST_SET:  state_d = run ? ST_RUN : ST_IDLE;
                ST_IDLE: state_d = run ? ST_RUN : ST_IDLE;
                ST_RUN:  state_d = run ? ST_RUN : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic: prescaler, digits and tick
    // -------------------------------------------------------------------------
    always_comb begin
        stay_run    = (state_q == ST_RUN) && (state_d == ST_RUN);
        period_done = stay_run && (presc_q == PRESC_LAST);
    end

    // Any cycle outside a continuous RUN stretch discards the partial period,
    // so a resume always waits a full TICK_DIV cycles.
    always_comb begin
        presc_d = '0;
        if (stay_run && !period_done) begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        tick_d = 1'b0;
        if (state_d == ST_SET) begin
            // Presets are re-applied every edge so `set9` changes are tracked.
            tens_d = set9[1] ? 4'd9 : 4'd0;
            ones_d = set9[0] ? 4'd9 : 4'd0;
        end else if (period_done) begin
            if (ones_q < 4'd9) begin
                ones_d = ones_q + 4'd1;
                tick_d = 1'b1;
            end else if (tens_q < 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
                tick_d = 1'b1;
            end else begin
`ifdef DIGIT_COUNTER_WRAP_EN
                ones_d = 4'd0;
                tens_d = 4'd0;
                tick_d = 1'b1;
`else
                // Saturate at 99: value holds and no tick is reported.
                ones_d = ones_q;
                tens_d = tens_q;
                tick_d = 1'b0;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            tick_q  <= tick_d;
        end
    end

    assign tens   = tens_q;
    assign ones   = ones_q;
    assign tick   = tick_q;
    assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

endmodule
